wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: two per-source FIFOs (ALU, LSU) feeding a single
// register-file write port through a round-robin grant.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef logic [36:0] ent_t;

  ent_t          mem_q [2][DEPTH];
  logic [PW-1:0] wp_q  [2];
  logic [PW-1:0] rp_q  [2];
  logic [CW-1:0] cnt_q [2];
  ent_t          wdat  [2];
  ent_t          head  [2];

  logic        prio_q, prio_d;
  logic [4:0]  crd_q, crd_d;
  logic [31:0] cdat_q, cdat_d;

  logic [1:0] vld, full, nemp, push, pop, gnt;
  logic       go;

  assign vld     = {lsu_valid, alu_valid};
  assign wdat[0] = {alu_rd, alu_data};
  assign wdat[1] = {lsu_rd, lsu_data};
  assign go      = rdy & ~flush;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      full[s] = (cnt_q[s] == CW'(DEPTH));
      nemp[s] = (cnt_q[s] != '0);
      head[s] = mem_q[s][rp_q[s]];
      // rd==0 completes the handshake but never occupies a slot
      push[s] = go & vld[s] & ~full[s] & (wdat[s][36:32] != 5'd0);
    end
  end

  assign alu_ready = rst & rdy & ~full[0];
  assign lsu_ready = rst & rdy & ~full[1];

  assign gnt[1] = nemp[1] & (~nemp[0] | prio_q);
  assign gnt[0] = nemp[0] & ~gnt[1];
  assign pop    = gnt & {2{go}};

  always_comb begin
    prio_d = prio_q;
    crd_d  = crd_q;
    cdat_d = cdat_q;
    if (rdy) begin
      crd_d = 5'd0;
      if (flush) begin
        prio_d = 1'b0;
      end else begin
        unique case (1'b1)
          gnt[0]: begin
            prio_d          = 1'b1;
            {crd_d, cdat_d} = head[0];
          end
          gnt[1]: begin
            prio_d          = 1'b0;
            {crd_d, cdat_d} = head[1];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
      crd_q  <= 5'd0;
      cdat_q <= 32'd0;
      for (int s = 0; s < 2; s++) begin
        wp_q[s]  <= '0;
        rp_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
    end else if (rdy) begin
      prio_q <= prio_d;
      crd_q  <= crd_d;
      cdat_q <= cdat_d;
      for (int s = 0; s < 2; s++) begin
        if (flush) begin
          wp_q[s]  <= '0;
          rp_q[s]  <= '0;
          cnt_q[s] <= '0;
        end else begin
          if (push[s]) wp_q[s] <= wp_q[s] + 1'b1;
          if (pop[s])  rp_q[s] <= rp_q[s] + 1'b1;
          cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
        end
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q alone
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem_q[s][wp_q[s]] <= wdat[s];
    end
  end

  assign commit_rd   = crd_q;
  assign commit_data = cdat_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        flush = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        lsu_ready;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd),
    .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .commit_rd(commit_rd), .commit_data(commit_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [36:0] aq[$];
  logic [36:0] lq[$];
  bit          m_prio = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_dat = '0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    lq.delete();
    m_prio = 1'b0;
    m_rd   = '0;
    m_dat  = '0;
  endtask

  // One clock edge of behaviour, from the rules, using current inputs
  task automatic model_step();
    bit acc_a, acc_l;
    logic [36:0] e;
    if (!rdy) return;
    if (flush) begin
      aq.delete();
      lq.delete();
      m_prio = 1'b0;
      m_rd   = '0;
      return;
    end
    acc_a = alu_valid && (aq.size() < DEPTH);
    acc_l = lsu_valid && (lsu_valid && lq.size() < DEPTH);
    m_rd = '0;
    if (aq.size() > 0 && lq.size() > 0) begin
      if (m_prio) e = lq.pop_front();
      else        e = aq.pop_front();
      {m_rd, m_dat} = e;
      m_prio = ~m_prio;
    end else if (aq.size() > 0) begin
      {m_rd, m_dat} = aq.pop_front();
      m_prio = 1'b1;
    end else if (lq.size() > 0) begin
      {m_rd, m_dat} = lq.pop_front();
      m_prio = 1'b0;
    end
    if (acc_a && alu_rd != 0) aq.push_back({alu_rd, alu_data});
    if (acc_l && lsu_rd != 0) lq.push_back({lsu_rd, lsu_data});
  endtask

  // Drive inputs just after a falling edge, check, then advance one cycle
  task automatic cyc(input logic r, input logic f,
                     input logic av, input logic [4:0] ard,
                     input logic [31:0] adat,
                     input logic lv, input logic [4:0] lrd,
                     input logic [31:0] ldat);
    rdy = r; flush = f;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    #1;
    check("alu_ready", 32'(alu_ready),
          32'(rst && r && aq.size() < DEPTH));
    check("lsu_ready", 32'(lsu_ready),
          32'(rst && r && lq.size() < DEPTH));
    check("commit_rd", 32'(commit_rd), 32'(m_rd));
    check("commit_data", commit_data, m_dat);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset pulse placed between edges
  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rst_rd", 32'(commit_rd), 32'd0);
    check("rst_data", commit_data, 32'd0);
    check("rst_ardy", 32'(alu_ready), 32'd0);
    check("rst_lrdy", 32'(lsu_ready), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1;
    check("rst0_rd", 32'(commit_rd), 32'd0);
    check("rst0_data", commit_data, 32'd0);
    rdy = 1'b1;
    #1;
    check("rst0_ardy", 32'(alu_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single ALU request: visible after the second edge only
    cyc(1, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("single_e0", 32'(commit_rd), 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("single_e1_rd", 32'(commit_rd), 32'd5);
    check("single_e1_d", commit_data, 32'hDEADBEEF);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("single_e2", 32'(commit_rd), 32'd0);
    idle(2);

    // both sources every cycle: alternation with no gaps
    for (int i = 0; i < 10; i++)
      cyc(1, 0, 1, 1, 32'(100 + i), 1, 2, 32'(200 + i));
    idle(6);

    // contention fills the ALU queue; then flush with a push
    for (int i = 0; i < 6; i++)
      cyc(1, 0, 1, 5'(3 + i), 32'(i), 1, 5'(9 + i), 32'(i));
    cyc(1, 1, 1, 7, 32'h77, 0, 0, 0);
    check("flush_rd", 32'(commit_rd), 32'd0);
    idle(3);

    // fill, then freeze with rdy low, then resume
    for (int i = 0; i < 6; i++)
      cyc(1, 0, 1, 5'(20 + i), 32'(i), 1, 5'(25 + i), 32'(i));
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 1, 32'h1, 1, 1, 32'h1);
    idle(6);

    // reset with entries queued, then an rd=0 request
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 1, 5'(10 + i), 32'(i), 1, 5'(15 + i), 32'(i));
    pulse_reset();
    idle(3);
    cyc(1, 0, 1, 0, 32'h1234, 0, 0, 0);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic r, f;
      logic [4:0] ar, lr;
      r  = ($urandom_range(0, 99) >= 12);
      f  = ($urandom_range(0, 99) < 4);
      ar = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      lr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 199) == 0) pulse_reset();
      cyc(r, f, 1'($urandom_range(0, 99) < 70), ar, $urandom,
          1'($urandom_range(0, 99) < 70), lr, $urandom);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
